shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Control block for the 16-bit barrel shifter.
- Owns the shifter's configuration: shift amount, rotate/shift select, left/right select.
- Sequences the amount in four modes: manual hold, auto sweep, ping-pong, and single-step on a debounced button.
- Replaces the ad-hoc counter/config register pair between the switch registers and the shifter; its outputs drive the shifter's howmany/RorS/LorR directly.

Parameters:
- SIZE, 16: data width of the controlled shifter (informational; sets AMT_W).
- AMT_W, 4: width of the shift amount, equal to log2(SIZE).
- TICK_DIV, 50000000: clk cycles per automatic step. Benches override to 4.
- DIV_W, 26: prescaler width, at least ceil(log2(TICK_DIV)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  one-cycle strobe; loads all cfg_* inputs.
- cfg_mode  in  2  00 MANUAL, 01 SWEEP, 10 PINGPONG, 11 STEP.
- cfg_rotate  in  1  1 = rotate, 0 = logical shift.
- cfg_left  in  1  1 = left, 0 = right.
- cfg_amt  in  AMT_W  initial/manual shift amount.
- cfg_limit  in  AMT_W  upper bound of the amount sequence, inclusive.
- step_btn  in  1  raw asynchronous pushbutton; used in STEP mode.
- pause  in  1  level; freezes the prescaler and the amount.
- howmany  out  AMT_W  registered shift amount to the shifter.
- RorS  out  1  registered rotate/shift select.
- LorR  out  1  registered left/right select.
- tick  out  1  one-cycle pulse, asserted in the same cycle howmany takes a sequenced new value.
- mode  out  2  current FSM state, for LED display.

Behaviour:
- Reset (asynchronous, active-high):
  - howmany=0, RorS=0, LorR=0, tick=0, mode=MANUAL.
  - limit register = 2^AMT_W-1; prescaler=0; ping-pong direction=up; synchronizer flops=0.
- FSM states: MANUAL, SWEEP, PINGPONG, STEP. The state changes only on cfg_we, to cfg_mode. There are no other transitions.
- cfg_we effects, next edge:
  - Load RorS, LorR and limit.
  - howmany = min(cfg_amt, cfg_limit).
  - Prescaler cleared; direction=up; tick=0.
  - A reconfigure in the middle of a sequence aborts it cleanly.
- cfg_we has priority over any step event in the same cycle; that step is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 in SWEEP and PINGPONG only.
  - At TICK_DIV-1 it wraps to 0 and raises a step event.
  - First step lands exactly TICK_DIV cycles after the cfg_we edge.
  - Held at 0 in MANUAL and STEP.
- pause=1: prescaler holds its count; step events are suppressed (including STEP button edges); howmany holds.
- Step event in SWEEP and STEP: howmany = (howmany==limit) ? 0 : howmany+1.
- Step event in PINGPONG:
  - Going up: increment, and flip to down when the new value equals limit.
  - Going down: decrement, and flip to up when the new value equals 0.
  - limit=0: howmany stays 0 and tick still pulses.
- MANUAL: howmany never changes except through cfg_we. tick never pulses.
- STEP button path:
  - 2-flop synchronizer, then rising-edge detect (sync2 & ~prev).
  - Latency: howmany changes on the 3rd rising clk edge after step_btn goes high.
  - One step per press. A held button produces no repeat.
  - No debounce counter in this block; bounce filtering is upstream.
- tick is registered and high for exactly one cycle per applied step.
- All arithmetic is AMT_W-bit unsigned. Overflow is impossible because of the clamp-to-limit rule.

Decomposition:
- Shared package/header shift_seq_pkg: mode encodings MODE_MANUAL/SWEEP/PINGPONG/STEP (2-bit) and the default TICK_DIV.
- One sub-module, btn_sync_edge: 2-flop synchronizer plus edge detect, async active-high rst, output one-cycle pulse. It is reused for the other pushbuttons.
- Prescaler and FSM stay inline.

Test Plan:
- Reset mid-sweep (TICK_DIV=4, SWEEP, limit=15, howmany=7): assert rst asynchronously between edges -> all outputs 0 and mode=MANUAL immediately, before the next clk edge.
- SWEEP, TICK_DIV=4, cfg_amt=13, cfg_limit=15 -> howmany sequence 13,14,15,0,1, changing every 4 cycles; the first change is 4 cycles after cfg_we; tick pulses once at each change.
- PINGPONG, limit=3, amt=0 -> howmany 0,1,2,3,2,1,0,1. Also cfg_amt=9 with limit=3 -> howmany clamps to 3.
- STEP mode, step_btn held high for 20 cycles -> howmany +1 exactly once, on the 3rd edge after the rise; tick pulses once. With pause=1 during a press -> no change.
- cfg_we asserted in the same cycle a prescaler step is due -> the cfg value is loaded, no increment is applied, tick=0, and the next step comes TICK_DIV cycles later.
- MANUAL, cfg_rotate=1, cfg_left=0, cfg_amt=5 -> RorS=1, LorR=0, howmany=5 one cycle after cfg_we, and held for 100 cycles with no tick.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the barrel-shifter control block: mode encodings and
// the default automatic step rate.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'b00,
        MODE_SWEEP    = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_STEP     = 2'b11
    } mode_t;

    localparam int DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw pushbutton followed by a rising-edge detector
// that emits a one-cycle pulse per press.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/shift_sequencer.sv
// Configuration owner and amount sequencer for the 16-bit barrel shifter:
// manual hold, auto sweep, ping-pong and single-step on a button.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int AMT_W    = $clog2(SIZE),
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int DIV_W    = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_rotate,
    input  logic             cfg_left,
    input  logic [AMT_W-1:0] cfg_amt,
    input  logic [AMT_W-1:0] cfg_limit,
    input  logic             step_btn,
    input  logic             pause,
    output logic [AMT_W-1:0] howmany,
    output logic             RorS,
    output logic             LorR,
    output logic             tick,
    output logic [1:0]       mode
);

    mode_t            state;
    mode_t            state_next;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_next;
    logic [AMT_W-1:0] limit;
    logic [AMT_W-1:0] amt_next;
    logic             going_up;
    logic             dir_next;
    logic             tick_next;
    logic             step;
    logic             up_move;
    logic             timed;
    logic             btn_pulse;

    btn_sync_edge u_step_btn (
        .clk  (clk),
        .rst  (rst),
        .btn  (step_btn),
        .pulse(btn_pulse)
    );

    assign timed = (state == MODE_SWEEP) || (state == MODE_PINGPONG);

    always_comb begin
        state_next = state;
        presc_next = presc;
        amt_next   = howmany;
        dir_next   = going_up;
        tick_next  = 1'b0;
        step       = 1'b0;
        up_move    = 1'b0;

        if (!timed) begin
            presc_next = '0;
        end else if (!pause) begin
            if (presc == DIV_W'(TICK_DIV - 1)) begin
                presc_next = '0;
                step       = 1'b1;
            end else begin
                presc_next = presc + DIV_W'(1);
            end
        end

        if (state == MODE_STEP && !pause && btn_pulse) begin
            step = 1'b1;
        end

        if (step) begin
            tick_next = 1'b1;
            if (state == MODE_PINGPONG) begin
                // A start at the limit while heading up simply turns around.
                if (limit == '0) begin
                    amt_next = '0;
                end else begin
                    up_move  = going_up ? (howmany != limit) : (howmany == '0);
                    amt_next = up_move ? howmany + AMT_W'(1) : howmany - AMT_W'(1);
                    dir_next = up_move ? (amt_next != limit) : (amt_next == '0);
                end
            end else begin
                amt_next = (howmany == limit) ? '0 : howmany + AMT_W'(1);
            end
        end

        // Reconfiguration wins over any step due in the same cycle.
        if (cfg_we) begin
            state_next = mode_t'(cfg_mode);
            presc_next = '0;
            amt_next   = (cfg_amt > cfg_limit) ? cfg_limit : cfg_amt;
            dir_next   = 1'b1;
            tick_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MODE_MANUAL;
            presc    <= '0;
            howmany  <= '0;
            going_up <= 1'b1;
            tick     <= 1'b0;
            limit    <= '1;
            RorS     <= 1'b0;
            LorR     <= 1'b0;
        end else begin
            state    <= state_next;
            presc    <= presc_next;
            howmany  <= amt_next;
            going_up <= dir_next;
            tick     <= tick_next;
            if (cfg_we) begin
                limit <= cfg_limit;
                RorS  <= cfg_rotate;
                LorR  <= cfg_left;
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a closed-form sequence model checked
// every cycle, plus directed vectors with hand-computed values.
module tb_shift_sequencer;

    localparam int TB_TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic       cfg_rotate = 1'b0;
    logic       cfg_left = 1'b0;
    logic [3:0] cfg_amt = 4'd0;
    logic [3:0] cfg_limit = 4'd0;
    logic       step_btn = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] howmany;
    logic       RorS;
    logic       LorR;
    logic       tick;
    logic [1:0] mode;

    int num_checks = 0;
    int num_fails  = 0;

    // Model state
    int   m_mode, m_h, m_lim, m_start, m_k, m_cnt;
    logic m_ror, m_lor, m_tick;
    logic b1, b2, b3;

    shift_sequencer #(
        .SIZE(16), .AMT_W(4), .TICK_DIV(TB_TICK_DIV), .DIV_W(3)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
        .cfg_rotate(cfg_rotate), .cfg_left(cfg_left), .cfg_amt(cfg_amt),
        .cfg_limit(cfg_limit), .step_btn(step_btn), .pause(pause),
        .howmany(howmany), .RorS(RorS), .LorR(LorR), .tick(tick), .mode(mode)
    );

    always #5 clk = ~clk;

    // Amount after k steps from start a: sweep wraps modulo limit+1, ping-pong
    // folds a position running modulo 2*limit.
    function automatic int seqVal(int md, int a, int lim, int k);
        int p;
        if (md == 2) begin
            if (lim == 0) return 0;
            p = (a + k) % (2 * lim);
            return (p <= lim) ? p : 2 * lim - p;
        end
        return (a + k) % (lim + 1);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        num_checks++;
        if (actual != expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        int   cnt;
        logic due;
        logic evt;
        int   a;
        if (rst) begin
            m_mode <= 0; m_h <= 0; m_lim <= 15; m_start <= 0; m_k <= 0; m_cnt <= 0;
            m_ror <= 1'b0; m_lor <= 1'b0; m_tick <= 1'b0;
            b1 <= 1'b0; b2 <= 1'b0; b3 <= 1'b0;
        end else begin
            // Button seen two edges ago is high and three edges ago was low.
            evt = b2 & ~b3;
            b3 <= b2; b2 <= b1; b1 <= step_btn;
            if (cfg_we) begin
                a = (int'(cfg_amt) > int'(cfg_limit)) ? int'(cfg_limit) : int'(cfg_amt);
                m_mode <= int'(cfg_mode); m_ror <= cfg_rotate; m_lor <= cfg_left;
                m_lim <= int'(cfg_limit); m_start <= a; m_h <= a;
                m_k <= 0; m_cnt <= 0; m_tick <= 1'b0;
            end else begin
                due = 1'b0;
                cnt = m_cnt;
                if ((m_mode == 1 || m_mode == 2) && !pause) begin
                    cnt = m_cnt + 1;
                    if (cnt == TB_TICK_DIV) begin
                        cnt = 0;
                        due = 1'b1;
                    end
                end
                if (m_mode == 3 && !pause && evt) due = 1'b1;
                m_cnt  <= cnt;
                m_tick <= due;
                if (due) begin
                    m_k <= m_k + 1;
                    m_h <= seqVal(m_mode, m_start, m_lim, m_k + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("model howmany", int'(howmany), m_h);
            checkOutput("model tick", int'(tick), int'(m_tick));
            checkOutput("model RorS", int'(RorS), int'(m_ror));
            checkOutput("model LorR", int'(LorR), int'(m_lor));
            checkOutput("model mode", int'(mode), m_mode);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] md, input logic rot, input logic lft,
                                 input logic [3:0] amt, input logic [3:0] lim);
        @(posedge clk);
        #2;
        cfg_we = 1'b1; cfg_mode = md; cfg_rotate = rot; cfg_left = lft;
        cfg_amt = amt; cfg_limit = lim;
        @(posedge clk);
        #2;
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within bound");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int sweep_exp [4];
        int pp_exp [7];
        sweep_exp = '{14, 15, 0, 1};
        pp_exp    = '{1, 2, 3, 2, 1, 0, 1};

        #1;
        checkOutput("reset howmany", int'(howmany), 0);
        checkOutput("reset mode", int'(mode), 0);
        checkOutput("reset tick", int'(tick), 0);
        checkOutput("reset RorS", int'(RorS), 0);
        checkOutput("reset LorR", int'(LorR), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // MANUAL hold with no ticks
        applyStimulus(2'b00, 1'b1, 1'b0, 4'd5, 4'd15);
        checkOutput("manual howmany", int'(howmany), 5);
        checkOutput("manual RorS", int'(RorS), 1);
        checkOutput("manual LorR", int'(LorR), 0);
        for (int i = 0; i < 100; i++) begin
            waitCycles(1);
            checkOutput("manual no tick", int'(tick), 0);
        end
        checkOutput("manual held", int'(howmany), 5);

        // SWEEP wrap through the limit
        applyStimulus(2'b01, 1'b0, 1'b1, 4'd13, 4'd15);
        checkOutput("sweep start", int'(howmany), 13);
        for (int i = 0; i < 4; i++) begin
            waitCycles(3);
            checkOutput("sweep hold", int'(howmany), (i == 0) ? 13 : sweep_exp[i-1]);
            checkOutput("sweep hold tick", int'(tick), 0);
            waitCycles(1);
            checkOutput("sweep step", int'(howmany), sweep_exp[i]);
            checkOutput("sweep step tick", int'(tick), 1);
        end

        // Reconfigure on the cycle a step is due
        applyStimulus(2'b01, 1'b0, 1'b0, 4'd2, 4'd15);
        waitCycles(2);
        applyStimulus(2'b01, 1'b0, 1'b0, 4'd9, 4'd15);
        checkOutput("collide load", int'(howmany), 9);
        checkOutput("collide tick", int'(tick), 0);
        waitCycles(3);
        checkOutput("collide hold", int'(howmany), 9);
        waitCycles(1);
        checkOutput("collide next", int'(howmany), 10);
        checkOutput("collide next tick", int'(tick), 1);

        // Pause freezes the prescaler mid-count
        applyStimulus(2'b01, 1'b0, 1'b0, 4'd0, 4'd15);
        waitCycles(2);
        pause = 1'b1;
        waitCycles(3);
        checkOutput("pause hold", int'(howmany), 0);
        pause = 1'b0;
        waitCycles(1);
        checkOutput("pause resume hold", int'(howmany), 0);
        waitCycles(1);
        checkOutput("pause resume step", int'(howmany), 1);

        // PINGPONG bounce and clamp
        applyStimulus(2'b10, 1'b1, 1'b1, 4'd0, 4'd3);
        for (int i = 0; i < 7; i++) begin
            waitCycles(4);
            checkOutput("pingpong", int'(howmany), pp_exp[i]);
        end
        applyStimulus(2'b10, 1'b0, 1'b0, 4'd9, 4'd3);
        checkOutput("pingpong clamp", int'(howmany), 3);
        waitCycles(4);
        checkOutput("pingpong turn", int'(howmany), 2);
        applyStimulus(2'b10, 1'b0, 1'b0, 4'd0, 4'd0);
        waitCycles(4);
        checkOutput("pingpong lim0 amt", int'(howmany), 0);
        checkOutput("pingpong lim0 tick", int'(tick), 1);

        // STEP: one step per press, on the third edge
        applyStimulus(2'b11, 1'b0, 1'b0, 4'd0, 4'd15);
        step_btn = 1'b1;
        waitCycles(2);
        checkOutput("step latency", int'(howmany), 0);
        waitCycles(1);
        checkOutput("step applied", int'(howmany), 1);
        checkOutput("step tick", int'(tick), 1);
        waitCycles(1);
        checkOutput("step tick once", int'(tick), 0);
        waitCycles(16);
        step_btn = 1'b0;
        waitCycles(3);
        checkOutput("step no repeat", int'(howmany), 1);
        pause = 1'b1;
        step_btn = 1'b1;
        waitCycles(10);
        step_btn = 1'b0;
        waitCycles(4);
        pause = 1'b0;
        waitCycles(4);
        checkOutput("step paused press", int'(howmany), 1);
        step_btn = 1'b1;
        waitCycles(3);
        checkOutput("step second press", int'(howmany), 2);
        step_btn = 1'b0;
        waitCycles(3);

        // Asynchronous reset in the middle of a sweep
        applyStimulus(2'b01, 1'b1, 1'b1, 4'd7, 4'd15);
        waitCycles(1);
        checkOutput("pre-reset howmany", int'(howmany), 7);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async rst howmany", int'(howmany), 0);
        checkOutput("async rst mode", int'(mode), 0);
        checkOutput("async rst RorS", int'(RorS), 0);
        checkOutput("async rst LorR", int'(LorR), 0);
        checkOutput("async rst tick", int'(tick), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        waitCycles(6);
        checkOutput("post-reset manual", int'(howmany), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
